// File: rtl/cpu_sequencer_if.sv
// Bundle of the sequencer's control inputs and status outputs.
// master: the sequencer itself; slave: the datapath/memory side driving it.
interface cpu_sequencer_if #(
    parameter int OPW   = 4,
    parameter int CNT_W = 8
);
    logic [OPW-1:0]   opcode;
    logic             zero_flag;
    logic             mem_ack;
    logic             resume;
    logic [3:0]       state;
    logic             allow_up;
    logic             mem_req;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, zero_flag, mem_ack, resume,
        output state, allow_up, mem_req, halted, fault, instr_count
    );

    modport slave (
        output opcode, zero_flag, mem_ack, resume,
        input  state, allow_up, mem_req, halted, fault, instr_count
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: fetch (PC/RAM/IR), decode (BUFFER),
// execute (REG_IN..ROM), jumps, halt with resume, and a sticky fault
// raised when memory fails to acknowledge within TIMEOUT cycles.
module cpu_sequencer #(
    parameter int             OPW     = 4,
    parameter logic [OPW-1:0] JUMP_OP = 4'hF,
    parameter logic [OPW-1:0] JZ_OP   = 4'hD,
    parameter logic [OPW-1:0] HALT_OP = 4'hE,
    parameter int             TIMEOUT = 8,
    parameter int             CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_PC      = 4'd1,
        S_RAM     = 4'd2,
        S_IR      = 4'd3,
        S_BUFFER  = 4'd4,
        S_REG_IN  = 4'd5,
        S_ALU     = 4'd6,
        S_ALU_OUT = 4'd7,
        S_REG_OUT = 4'd8,
        S_ROM     = 4'd9,
        S_JUMP    = 4'd10,
        S_HALT    = 4'd11,
        S_FAULT   = 4'd12
    } state_t;

    // Wide enough to hold TIMEOUT-1; at least one bit when TIMEOUT is 1.
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [WW-1:0]    wait_cnt_reg, wait_cnt_next;
    logic             allow_up_reg, allow_up_next;
    logic [CNT_W-1:0] instr_count_reg, instr_count_next;

    // State, memory wait counter, write-back enable and instruction counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            wait_cnt_reg    <= '0;
            allow_up_reg    <= 1'b0;
            instr_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            allow_up_reg    <= allow_up_next;
            instr_count_reg <= instr_count_next;
        end
    end

    // Next-state decode plus the counters and write-back enable updates.
    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = '0;
        allow_up_next    = allow_up_reg;
        instr_count_next = instr_count_reg;

        case (state_reg)
            S_IDLE:    state_next = S_PC;
            S_PC:      state_next = S_RAM;
            S_RAM: begin
                // Ack on the final allowed cycle still counts as success.
                if (bus.mem_ack) begin
                    state_next = S_IR;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = S_FAULT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_IR:      state_next = S_BUFFER;
            S_BUFFER: begin
                if (bus.opcode == JUMP_OP) begin
                    state_next = S_JUMP;
                end else if (bus.opcode == JZ_OP) begin
                    // Untaken conditional jump skips execution entirely.
                    state_next = bus.zero_flag ? S_JUMP : S_ROM;
                end else if (bus.opcode == HALT_OP) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_REG_IN;
                end
            end
            S_REG_IN:  state_next = S_ALU;
            S_ALU:     state_next = S_ALU_OUT;
            S_ALU_OUT: state_next = S_REG_OUT;
            S_REG_OUT: state_next = S_ROM;
            S_ROM:     state_next = S_PC;
            S_JUMP:    state_next = S_RAM;
            S_HALT:    state_next = bus.resume ? S_PC : S_HALT;
            S_FAULT:   state_next = S_FAULT;
            default:   state_next = S_IDLE;
        endcase

        // Write-back is armed once the ALU result is out and dropped on the next fetch.
        if (state_reg == S_RAM) begin
            allow_up_next = 1'b0;
        end else if (state_reg == S_ALU_OUT) begin
            allow_up_next = 1'b1;
        end

        // Every decode counts, whatever the opcode turns out to be.
        if (state_reg == S_BUFFER) begin
            instr_count_next = instr_count_reg + 1'b1;
        end
    end

    assign bus.state       = state_reg;
    assign bus.allow_up    = allow_up_reg;
    assign bus.instr_count = instr_count_reg;
    assign bus.mem_req     = (state_reg == S_RAM);
    assign bus.halted      = (state_reg == S_HALT);
    assign bus.fault       = (state_reg == S_FAULT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: expected cycle-by-cycle status is queued
// as each step is driven and checked once the DUT has clocked it out.
// A second instance with a 2-bit counter shares the stimulus to check wrap.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cpu_sequencer_if #(.OPW(4), .CNT_W(8)) bus ();
    cpu_sequencer_if #(.OPW(4), .CNT_W(2)) bus2 ();

    cpu_sequencer #(.TIMEOUT(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cpu_sequencer #(.TIMEOUT(8), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    assign bus2.opcode    = bus.opcode;
    assign bus2.zero_flag = bus.zero_flag;
    assign bus2.mem_ack   = bus.mem_ack;
    assign bus2.resume    = bus.resume;

    typedef struct {
        logic [3:0] st;
        logic       au;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic push(input logic [3:0] st, input logic au, input logic [7:0] cnt);
        exp_t e;
        e.st  = st;
        e.au  = au;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        logic [1:0] c2;
        tests++;
        assert (sb.size() > 0) else begin
            failed++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            c2 = e.cnt[1:0];
            tests++;
            assert (bus.state === e.st) else begin
                failed++;
                $error("FAIL state observed=%0d expected=%0d", bus.state, e.st);
            end
            tests++;
            assert (bus.allow_up === e.au) else begin
                failed++;
                $error("FAIL allow_up observed=%b expected=%b (state %0d)", bus.allow_up, e.au, e.st);
            end
            tests++;
            assert (bus.instr_count === e.cnt) else begin
                failed++;
                $error("FAIL instr_count observed=%0d expected=%0d", bus.instr_count, e.cnt);
            end
            tests++;
            assert (bus.mem_req === (e.st == 4'd2)) else begin
                failed++;
                $error("FAIL mem_req observed=%b expected=%b", bus.mem_req, (e.st == 4'd2));
            end
            tests++;
            assert (bus.halted === (e.st == 4'd11)) else begin
                failed++;
                $error("FAIL halted observed=%b expected=%b", bus.halted, (e.st == 4'd11));
            end
            tests++;
            assert (bus.fault === (e.st == 4'd12)) else begin
                failed++;
                $error("FAIL fault observed=%b expected=%b", bus.fault, (e.st == 4'd12));
            end
            tests++;
            assert (bus2.instr_count === c2) else begin
                failed++;
                $error("FAIL instr_count_w2 observed=%0d expected=%0d", bus2.instr_count, c2);
            end
            $display("[TB] t=%0t state=%0d allow_up=%b count=%0d count_w2=%0d",
                     $time, bus.state, bus.allow_up, bus.instr_count, bus2.instr_count);
        end
    endtask

    // Queue the expectation, let one rising edge happen, then check after it.
    task automatic step(input logic [3:0] st, input logic au, input logic [7:0] cnt);
        push(st, au, cnt);
        @(posedge clk);
        #1;
        compare();
    endtask

    // Check without any clock edge (used right after asynchronous reset).
    task automatic expect_now(input logic [3:0] st, input logic au, input logic [7:0] cnt);
        push(st, au, cnt);
        compare();
    endtask

    // One ordinary instruction from IR back to IR with zero-wait memory.
    task automatic alu_loop(input logic [7:0] c);
        logic [7:0] n;
        n = c + 8'd1;
        step(4'd4,  1'b0, c);
        step(4'd5,  1'b0, n);
        step(4'd6,  1'b0, n);
        step(4'd7,  1'b0, n);
        step(4'd8,  1'b1, n);
        step(4'd9,  1'b1, n);
        step(4'd1,  1'b1, n);
        step(4'd2,  1'b1, n);
        step(4'd3,  1'b0, n);
    endtask

    initial begin
        rst           = 1'b1;
        bus.opcode    = 4'h1;
        bus.zero_flag = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.resume    = 1'b0;
        #2;
        expect_now(4'd0, 1'b0, 8'd0);

        // Reset release and two ordinary instructions.
        @(negedge clk);
        rst = 1'b0;
        step(4'd1, 1'b0, 8'd0);
        step(4'd2, 1'b0, 8'd0);
        step(4'd3, 1'b0, 8'd0);
        alu_loop(8'd0);
        alu_loop(8'd1);

        // Conditional jump taken.
        bus.opcode    = 4'hD;
        bus.zero_flag = 1'b1;
        step(4'd4,  1'b0, 8'd2);
        step(4'd10, 1'b0, 8'd3);
        step(4'd2,  1'b0, 8'd3);
        step(4'd3,  1'b0, 8'd3);

        // Conditional jump not taken: execution skipped.
        bus.zero_flag = 1'b0;
        step(4'd4, 1'b0, 8'd3);
        step(4'd9, 1'b0, 8'd4);
        step(4'd1, 1'b0, 8'd4);
        step(4'd2, 1'b0, 8'd4);
        step(4'd3, 1'b0, 8'd4);

        // Unconditional jump, then memory never acknowledges.
        bus.opcode = 4'hF;
        step(4'd4,  1'b0, 8'd4);
        step(4'd10, 1'b0, 8'd5);
        step(4'd2,  1'b0, 8'd5);
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 7; i++) step(4'd2, 1'b0, 8'd5);
        step(4'd12, 1'b0, 8'd5);

        // Fault is sticky regardless of ack or resume.
        bus.mem_ack = 1'b1;
        bus.resume  = 1'b1;
        for (int i = 0; i < 3; i++) step(4'd12, 1'b0, 8'd5);

        // Asynchronous reset out of FAULT.
        #2;
        rst = 1'b1;
        #1;
        expect_now(4'd0, 1'b0, 8'd0);
        @(negedge clk);
        rst         = 1'b0;
        bus.resume  = 1'b0;
        bus.opcode  = 4'h1;

        // Ack arrives on the eighth RAM cycle: no fault.
        step(4'd1, 1'b0, 8'd0);
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) step(4'd2, 1'b0, 8'd0);
        bus.mem_ack = 1'b1;
        step(4'd3, 1'b0, 8'd0);

        // Halt, hold for five cycles, then resume.
        bus.opcode = 4'hE;
        step(4'd4, 1'b0, 8'd0);
        step(4'd11, 1'b0, 8'd1);
        for (int i = 0; i < 5; i++) step(4'd11, 1'b0, 8'd1);
        bus.resume = 1'b1;
        step(4'd1, 1'b0, 8'd1);

        // Wait counter must have restarted: a short wait must not fault.
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) step(4'd2, 1'b0, 8'd1);
        bus.mem_ack = 1'b1;
        step(4'd3, 1'b0, 8'd1);

        // Four more instructions, wrapping the 2-bit counter.
        bus.resume = 1'b0;
        bus.opcode = 4'h1;
        alu_loop(8'd1);
        alu_loop(8'd2);
        alu_loop(8'd3);
        alu_loop(8'd4);

        // Asynchronous reset between edges while in ALU.
        step(4'd4, 1'b0, 8'd5);
        step(4'd5, 1'b0, 8'd6);
        step(4'd6, 1'b0, 8'd6);
        #3;
        rst = 1'b1;
        #1;
        expect_now(4'd0, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        step(4'd1, 1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter OPW, 4, opcode width in bits (>=2).
REQ-002 Parameter JUMP_OP, 4'hF (OPW bits), unconditional jump opcode.
REQ-003 Parameter JZ_OP, 4'hD, jump-if-zero opcode.
REQ-004 Parameter HALT_OP, 4'hE, halt opcode.
REQ-005 Parameter TIMEOUT, 8, max cycles in RAM state awaiting mem_ack (>=1).
REQ-006 Parameter CNT_W, 8, width of instr_count.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 rst  input  1  reset, asynchronous and active-high.
REQ-009 opcode  input  OPW  current instruction opcode, sampled in BUFFER.
REQ-010 zero_flag  input  1  ALU zero flag, sampled in BUFFER.
REQ-011 mem_ack  input  1  memory read complete, sampled in RAM.
REQ-012 resume  input  1  leave HALT, sampled in HALT only.
REQ-013 state  output  4  registered current state code.
REQ-014 allow_up  output  1  registered register-file write-back enable.
REQ-015 mem_req  output  1  memory read request, combinational, high iff state==RAM.
REQ-016 halted  output  1  combinational, high iff state==HALT.
REQ-017 fault  output  1  combinational, high iff state==FAULT.
REQ-018 instr_count  output  CNT_W  registered decoded-instruction counter.

Function
REQ-019 State codes SHALL be: IDLE 0, PC 1, RAM 2, IR 3, BUFFER 4, REG_IN 5, ALU 6, ALU_OUT 7, REG_OUT 8, ROM 9, JUMP 10, HALT 11, FAULT 12; codes 13-15 SHALL go to IDLE next edge.
REQ-020 Fixed transitions: IDLE->PC, PC->RAM, IR->BUFFER, REG_IN->ALU, ALU->ALU_OUT, ALU_OUT->REG_OUT, REG_OUT->ROM, ROM->PC, JUMP->RAM, each in one cycle.
REQ-021 RAM: mem_ack=1 -> IR; else wait counter increments; when counter reaches TIMEOUT-1 with mem_ack=0 -> FAULT (i.e. FAULT after exactly TIMEOUT cycles in RAM without ack).
REQ-022 mem_ack=1 on the timeout cycle SHALL win: go to IR, no FAULT.
REQ-023 Wait counter SHALL clear on every exit from RAM and on reset.
REQ-024 BUFFER decode priority: JUMP_OP -> JUMP; JZ_OP with zero_flag=1 -> JUMP; JZ_OP with zero_flag=0 -> ROM (execution skipped); HALT_OP -> HALT; any other -> REG_IN.
REQ-025 HALT: stay while resume=0; resume=1 -> PC next edge; resume ignored in all other states.
REQ-026 FAULT: sticky, exits only via rst.
REQ-027 allow_up SHALL go 1 on the edge leaving ALU_OUT, and 0 on any edge where state==RAM; otherwise hold.
REQ-028 instr_count SHALL increment by 1 on every edge where state==BUFFER (including HALT/jump decodes), wrapping from 2^CNT_W-1 to 0.
REQ-029 Full non-jump instruction loop PC..ROM SHALL take 9 cycles with zero-wait memory; jump path BUFFER->JUMP->RAM takes 2 cycles.

Reset
REQ-030 rst=1 SHALL immediately, without clk, force state=IDLE, allow_up=0, instr_count=0, wait counter=0; mem_req, halted, fault SHALL read 0.
REQ-031 Reset asserted mid-operation (any state, incl. HALT, FAULT) SHALL give the same result; first edge after release goes IDLE->PC.

Verification
REQ-032 Reset release, mem_ack=1 constant, opcode=4'h1 -> state 0,1,2,3,4,5,6,7,8,9,1; allow_up 1 during REG_OUT, ROM, PC; instr_count=1 after first BUFFER.
REQ-033 opcode=4'hD, zero_flag=1 -> BUFFER->JUMP->RAM; zero_flag=0 -> BUFFER->ROM->PC; allow_up unchanged.
REQ-034 mem_ack held 0, TIMEOUT=8 -> 8 cycles in RAM with mem_req=1, then state=12, fault=1, stays until rst; repeat with mem_ack=1 on 8th cycle -> IR, fault=0.
REQ-035 opcode=4'hE -> HALT, halted=1 for 5 cycles with resume=0; resume=1 -> PC next edge.
REQ-036 CNT_W=2, run 5 instructions -> instr_count 1,2,3,0,1.
REQ-037 rst pulsed asynchronously between edges during ALU -> state=0, allow_up=0, instr_count=0 before next clk edge.
